vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates VGA raster timing and drives the pixel-coordinate and lock interface consumed by the renderer (X, Y, lock).
- Accepts the renderer's registered RGB, realigns the sync and blank signals to it, and drives the DAC/connector pins.
- Sits between the top level (VGA pins) and the renderer.
- i_clk is the pixel clock: 25 MHz for 640x480@60.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- RENDER_LAT, 1, clocks from coordinate presented to matching RGB at i_VGA_R/G/B (range 0..4)

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  asynchronous reset, active-high
- i_VGA_R / i_VGA_G / i_VGA_B  in  8 each  pixel colour from renderer
- o_VGA_X  out  11  current pixel column; 0 outside active
- o_VGA_Y  out  11  current pixel row; 0 outside active
- o_VGA_lock  out  1  high while the vertical counter is in the active region; low during vertical blanking (renderer may update its data)
- o_frame_start  out  1  one-cycle pulse coincident with presentation of pixel (0,0)
- o_VGA_R / o_VGA_G / o_VGA_B  out  8 each  pin colour, forced 0 while blanked
- o_VGA_HS, o_VGA_VS  out  1 each  syncs, negative polarity
- o_VGA_BLANK_N  out  1  high during active pixels
- o_VGA_SYNC_N  out  1  tied 0

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H_* parameters (800).
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL = sum of the four V_* parameters (525).
  - Ordering within each axis: active, front porch, sync, back porch.
- Wrap rules:
  - h_cnt at H_TOTAL-1 wraps to 0 and v_cnt increments.
  - When both counters are at their last value, both wrap to 0 in the same cycle.
- Outputs are registered from the counters.
  - First clock edge after reset deasserts: X=0, Y=0, lock=1, frame_start=1.
  - X then increments every clock through 639, then reads 0 for the 160 blank clocks.
- o_VGA_lock:
  - High when v_cnt < V_ACTIVE, including the horizontal blanking within active lines.
  - Falls with the first presentation of line 480; rises with the presentation of (0,0).
- Sync timing at coordinate-presentation time:
  - hs_raw is low for h_cnt in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vs_raw is low for v_cnt in 490..491, for whole lines.
  - blank_raw is high when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Alignment: hs/vs/blank pass through a shift register of depth RENDER_LAT+1. Colour is captured into the output register at the same edge. Pin outputs for coordinate P therefore appear RENDER_LAT+1 clocks after P is presented on X/Y.
- Colour gating: o_VGA_R/G/B = i_VGA_* when delayed blank is high, else 0.
- Reset values: X=0, Y=0, lock=0, frame_start=0, RGB=0, HS=1, VS=1, BLANK_N=0, SYNC_N=0, counters 0, whole delay line cleared to the inactive state.
- Reset mid-frame: every output takes its reset value immediately. On release, the raster restarts at (0,0) with no partial sync pulse.
- There are no handshakes. The renderer must tolerate lock falling on any line boundary; lock never toggles inside a line.

Optional Feature:
- Macro: VGA_TESTPAT_EN
- Defined:
  - Adds input i_testpat (1 bit).
  - While i_testpat=1, pin colour comes from an internal 8-bar generator instead of i_VGA_*. Bar index = X[9:7] of the pipelined X; colour = {R,G,B} = bar index bits 2,1,0 each expanded to 8'hFF/8'h00.
  - The generator is pipelined to identical latency.
  - i_testpat is sampled once per frame at frame_start.
- Not defined: the port is absent and pin colour always comes from i_VGA_*.

Decomposition:
- Package vga_pkg:
  - timing constants for 640x480@60
  - typedef coord_t = logic [10:0]
  - typedef rgb_t = struct {R, G, B 8 bits each}
- Sub-module vga_sync_pipe: parameterised-depth shift register for {hs, vs, blank}, with asynchronous reset to the inactive values.

Test Plan:
- Reset then release, RENDER_LAT=1 -> cycle 1: X=0, Y=0, lock=1, frame_start=1; HS=VS=1 and BLANK_N=0 held until the delayed blank reaches the pins at cycle 3.
- Count a line -> BLANK_N high for 640 clocks and low for 160; HS low for exactly 96 clocks, starting 656+2 clocks after X=0 is presented.
- Count a frame -> lock low for exactly 45*800=36000 clocks; frame_start period 420000 clocks; VS low for exactly 1600 clocks.
- Renderer model returns i_VGA_R=X[7:0], i_VGA_G=Y[7:0] with 1-cycle latency -> pin R/G equal the coordinates presented 2 clocks earlier; pins are 0 while blanked.
- Assert i_rst at (x=300, y=200) for 3 clocks -> outputs take reset values within the same cycle; after release the sequence is identical to the first scenario.
- VGA_TESTPAT_EN defined, i_testpat=1 before frame_start -> columns 0..127 black, 128..255 blue (8'h00,8'h00,8'hFF), 896-column pattern not reached; columns 512..639 are bar 4, i.e. red.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480@60 VGA raster.
package vga_pkg;

  localparam int VGA_H_ACTIVE   = 640;
  localparam int VGA_H_FRONT    = 16;
  localparam int VGA_H_SYNC     = 96;
  localparam int VGA_H_BACK     = 48;
  localparam int VGA_V_ACTIVE   = 480;
  localparam int VGA_V_FRONT    = 10;
  localparam int VGA_V_SYNC     = 2;
  localparam int VGA_V_BACK     = 33;
  localparam int VGA_RENDER_LAT = 1;

  typedef logic [10:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  // Syncs are negative polarity, so the idle state is both high and blanked.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    bar_colour = '{r: {8{idx[2]}}, g: {8{idx[1]}}, b: {8{idx[0]}}};
  endfunction

endpackage

// File: rtl/vga_sync_pipe.sv
// Delay line for {hs, vs, blank} so the sync pins line up with the renderer's colour.
module vga_sync_pipe
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  i_clk,
  input  logic  i_rst,
  input  sync_t i_sync,
  output sync_t o_sync,
  output logic  o_tap_blank
);

  sync_t stage [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
    end else begin
      stage[0] <= i_sync;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign o_sync = stage[DEPTH-1];

  // Blank as it enters the last stage: gates colour loaded at the same edge.
  if (DEPTH == 1) begin : g_tap_in
    assign o_tap_blank = i_sync.blank;
  end else begin : g_tap_stage
    assign o_tap_blank = stage[DEPTH-2].blank;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing, renderer coordinate/lock interface and pin alignment.
// Optional VGA_TESTPAT_EN adds i_testpat and an 8-bar colour generator.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = VGA_H_ACTIVE,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_ACTIVE   = VGA_V_ACTIVE,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter int RENDER_LAT = VGA_RENDER_LAT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_VGA_R,
  input  logic [7:0]  i_VGA_G,
  input  logic [7:0]  i_VGA_B,
`ifdef VGA_TESTPAT_EN
  input  logic        i_testpat,
`endif
  output logic [10:0] o_VGA_X,
  output logic [10:0] o_VGA_Y,
  output logic        o_VGA_lock,
  output logic        o_frame_start,
  output logic [7:0]  o_VGA_R,
  output logic [7:0]  o_VGA_G,
  output logic [7:0]  o_VGA_B,
  output logic        o_VGA_HS,
  output logic        o_VGA_VS,
  output logic        o_VGA_BLANK_N,
  output logic        o_VGA_SYNC_N
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
  localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  coord_t h_cnt, v_cnt;
  coord_t x_q, y_q;
  logic   lock_q, fs_q;
  sync_t  sync_q, sync_raw, sync_pin;
  logic   h_act, v_act, tap_blank;
  rgb_t   pix_src, rgb_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
    end else begin
      h_cnt <= h_cnt + coord_t'(1);
    end
  end

  always_comb begin
    h_act          = (h_cnt < H_ACT);
    v_act          = (v_cnt < V_ACT);
    sync_raw.hs    = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    sync_raw.vs    = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    sync_raw.blank = h_act && v_act;
  end

  // Presentation stage: everything the renderer sees for the current counter value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q    <= '0;
      y_q    <= '0;
      lock_q <= 1'b0;
      fs_q   <= 1'b0;
      sync_q <= SYNC_IDLE;
    end else begin
      x_q    <= (h_act && v_act) ? h_cnt : '0;
      y_q    <= v_act ? v_cnt : '0;
      lock_q <= v_act;
      fs_q   <= (h_cnt == '0) && (v_cnt == '0);
      sync_q <= sync_raw;
    end
  end

  vga_sync_pipe #(
    .DEPTH (RENDER_LAT + 1)
  ) u_sync_pipe (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sync      (sync_q),
    .o_sync      (sync_pin),
    .o_tap_blank (tap_blank)
  );

`ifdef VGA_TESTPAT_EN
  logic [2:0] bar_tap;
  logic       testpat_q;

  // Bar index follows the same path length as the renderer's colour.
  if (RENDER_LAT == 0) begin : g_bar_direct
    assign bar_tap = x_q[9:7];
  end else begin : g_bar_delay
    logic [2:0] bar_d [RENDER_LAT];
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        for (int i = 0; i < RENDER_LAT; i++) bar_d[i] <= '0;
      end else begin
        bar_d[0] <= x_q[9:7];
        for (int i = 1; i < RENDER_LAT; i++) bar_d[i] <= bar_d[i-1];
      end
    end
    assign bar_tap = bar_d[RENDER_LAT-1];
  end

  // Latched on the raster origin so a frame is never half pattern, half renderer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      testpat_q <= 1'b0;
    end else if ((h_cnt == '0) && (v_cnt == '0)) begin
      testpat_q <= i_testpat;
    end
  end
`endif

  always_comb begin
    pix_src = '{r: i_VGA_R, g: i_VGA_G, b: i_VGA_B};
`ifdef VGA_TESTPAT_EN
    if (testpat_q) pix_src = bar_colour(bar_tap);
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= tap_blank ? pix_src : '0;
    end
  end

  assign o_VGA_X       = x_q;
  assign o_VGA_Y       = y_q;
  assign o_VGA_lock    = lock_q;
  assign o_frame_start = fs_q;
  assign o_VGA_R       = rgb_q.r;
  assign o_VGA_G       = rgb_q.g;
  assign o_VGA_B       = rgb_q.b;
  assign o_VGA_HS      = sync_pin.hs;
  assign o_VGA_VS      = sync_pin.vs;
  assign o_VGA_BLANK_N = sync_pin.blank;
  assign o_VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: scoreboarded default raster plus a shrunken raster for frame checks.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bn;
    logic [23:0] rgb;
  } pin_t;

  localparam pin_t PIN_IDLE = '{hs: 1'b1, vs: 1'b1, bn: 1'b0, rgb: 24'h0};

  logic clk = 1'b0;
  logic rst, rst_s;
  logic [7:0] vga_r, vga_g, vga_b;
  logic testpat;

  logic [10:0] x, y;
  logic lock, fs, hs, vs, bn, sn;
  logic [7:0] pr, pg, pb;

  logic [10:0] s_x, s_y;
  logic s_lock, s_fs, s_hs, s_vs, s_bn, s_sn;
  logic [7:0] s_r, s_g, s_b;

  int checks = 0;
  int errors = 0;
  int mh, mv;
  logic tp_mode;
  logic [10:0] prev_x, prev_y;
  pin_t sb[$];

  always #20 clk = ~clk;

  vga_timing_gen u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_VGA_R       (vga_r),
    .i_VGA_G       (vga_g),
    .i_VGA_B       (vga_b),
`ifdef VGA_TESTPAT_EN
    .i_testpat     (testpat),
`endif
    .o_VGA_X       (x),
    .o_VGA_Y       (y),
    .o_VGA_lock    (lock),
    .o_frame_start (fs),
    .o_VGA_R       (pr),
    .o_VGA_G       (pg),
    .o_VGA_B       (pb),
    .o_VGA_HS      (hs),
    .o_VGA_VS      (vs),
    .o_VGA_BLANK_N (bn),
    .o_VGA_SYNC_N  (sn)
  );

  // 48 x 15 raster so whole frames fit in a short run.
  vga_timing_gen #(
    .H_ACTIVE (32), .H_FRONT (4), .H_SYNC (6), .H_BACK (6),
    .V_ACTIVE (8),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .RENDER_LAT (2)
  ) u_small (
    .i_clk         (clk),
    .i_rst         (rst_s),
    .i_VGA_R       (8'hA5),
    .i_VGA_G       (8'h3C),
    .i_VGA_B       (8'hC3),
`ifdef VGA_TESTPAT_EN
    .i_testpat     (1'b0),
`endif
    .o_VGA_X       (s_x),
    .o_VGA_Y       (s_y),
    .o_VGA_lock    (s_lock),
    .o_frame_start (s_fs),
    .o_VGA_R       (s_r),
    .o_VGA_G       (s_g),
    .o_VGA_B       (s_b),
    .o_VGA_HS      (s_hs),
    .o_VGA_VS      (s_vs),
    .o_VGA_BLANK_N (s_bn),
    .o_VGA_SYNC_N  (s_sn)
  );

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk($sformatf("%s_x", tag), 32'(x), 0);
    chk($sformatf("%s_y", tag), 32'(y), 0);
    chk($sformatf("%s_lock", tag), 32'(lock), 0);
    chk($sformatf("%s_fs", tag), 32'(fs), 0);
    chk($sformatf("%s_sync", tag), 32'({hs, vs, bn}), 32'b110);
    chk($sformatf("%s_rgb", tag), 32'({pr, pg, pb}), 0);
    chk($sformatf("%s_sync_n", tag), 32'(sn), 0);
  endtask

  task automatic reset_model();
    mh = 0;
    mv = 0;
    sb.delete();
    sb.push_back(PIN_IDLE);
    sb.push_back(PIN_IDLE);
    prev_x = '0;
    prev_y = '0;
  endtask

  // One pixel clock of the default raster: check presentation, push its pin expectation,
  // pop the one due now, then act as a 1-clock-latency renderer.
  task automatic step_a();
    logic [10:0] ex, ey;
    logic ebn;
    logic [2:0] bar;
    pin_t e, got;
    @(negedge clk);
    ebn = (mh < 640) && (mv < 480);
    ex  = ebn ? 11'(mh) : 11'd0;
    ey  = (mv < 480) ? 11'(mv) : 11'd0;
    chk("pres_x", 32'(x), 32'(ex));
    chk("pres_y", 32'(y), 32'(ey));
    chk("pres_lock", 32'(lock), 32'(mv < 480));
    chk("pres_fs", 32'(fs), 32'((mh == 0) && (mv == 0)));
    chk("sync_n", 32'(sn), 0);
    e.hs = !((mh >= 656) && (mh <= 751));
    e.vs = !((mv >= 490) && (mv <= 491));
    e.bn = ebn;
    bar  = ex[9:7];
    if (!ebn) e.rgb = '0;
    else if (tp_mode) e.rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
    else e.rgb = {ex[7:0], ey[7:0], ex[7:0] ^ ey[7:0]};
    sb.push_back(e);
    e   = sb.pop_front();
    got = '{hs: hs, vs: vs, bn: bn, rgb: {pr, pg, pb}};
    chk("pin_sync", 32'({got.hs, got.vs, got.bn}), 32'({e.hs, e.vs, e.bn}));
    chk("pin_rgb", 32'(got.rgb), 32'(e.rgb));
    vga_r  = prev_x[7:0];
    vga_g  = prev_y[7:0];
    vga_b  = prev_x[7:0] ^ prev_y[7:0];
    prev_x = x;
    prev_y = y;
    mh++;
    if (mh == 800) begin
      mh = 0;
      mv = (mv == 524) ? 0 : mv + 1;
    end
  endtask

  initial begin
    int bn_cnt, hs_lo, hs_first;
    int lock_lo, lock_fall, fs_cnt, fs_first, fs_next;
    int vs_lo, vs_first, bn_hi, bn_first, r_hi, leak, vs_seen;
    rst = 1'b1;
    rst_s = 1'b1;
    vga_r = '0;
    vga_g = '0;
    vga_b = '0;
    testpat = 1'b0;
    tp_mode = 1'b0;
    bn_cnt = 0; hs_lo = 0; hs_first = 0;
    repeat (3) @(negedge clk);
    chk_reset_a("rst");

    // Default raster from release to (300,2).
    reset_model();
    rst = 1'b0;
    for (int k = 1; k <= 1901; k++) begin
      step_a();
      if (k >= 3 && k <= 802) begin
        if (bn) bn_cnt++;
        if (!hs) hs_lo++;
      end
      if (hs_first == 0 && !hs) hs_first = k;
    end
    chk("line_blank_n_high", 32'(bn_cnt), 640);
    chk("line_hs_low", 32'(hs_lo), 96);
    chk("hs_first_low_cycle", 32'(hs_first), 659);
    chk("pre_rst_x", 32'(x), 300);
    chk("pre_rst_y", 32'(y), 2);

    // Mid-frame reset: outputs fall back immediately, then the raster restarts at (0,0).
    rst = 1'b1;
    #1;
    chk_reset_a("midrst_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_a("midrst_hold");
    reset_model();
    rst = 1'b0;
    for (int k = 1; k <= 900; k++) step_a();

    // Shrunken raster: whole-frame counts.
    @(negedge clk);
    chk("s_rst_lock", 32'(s_lock), 0);
    chk("s_rst_fs", 32'(s_fs), 0);
    chk("s_rst_sync", 32'({s_hs, s_vs, s_bn}), 32'b110);
    chk("s_rst_rgb", 32'({s_r, s_g, s_b}), 0);
    rst_s = 1'b0;
    lock_lo = 0; lock_fall = 0; fs_cnt = 0; fs_first = 0; fs_next = 0;
    vs_lo = 0; vs_first = 0; bn_hi = 0; bn_first = 0; r_hi = 0; leak = 0;
    for (int k = 1; k <= 723; k++) begin
      @(negedge clk);
      if (k == 1) fs_first = int'(s_fs);
      if (k == 721) fs_next = int'(s_fs);
      if (k <= 720) begin
        if (!s_lock) lock_lo++;
        if (s_fs) fs_cnt++;
        if (lock_fall == 0 && !s_lock) lock_fall = k;
      end
      if (k >= 4) begin
        if (!s_vs) vs_lo++;
        if (s_bn) bn_hi++;
        if (s_r == 8'hA5) r_hi++;
        if (({s_r, s_g, s_b} != 24'h0) && !s_bn) leak++;
        if (bn_first == 0 && s_bn) bn_first = k;
        if (vs_first == 0 && !s_vs) vs_first = k;
      end
    end
    chk("s_fs_first", 32'(fs_first), 1);
    chk("s_fs_count", 32'(fs_cnt), 1);
    chk("s_fs_period", 32'(fs_next), 1);
    chk("s_lock_low", 32'(lock_lo), 336);
    chk("s_lock_fall_cycle", 32'(lock_fall), 385);
    chk("s_vs_low", 32'(vs_lo), 96);
    chk("s_vs_first_cycle", 32'(vs_first), 484);
    chk("s_blank_n_high", 32'(bn_hi), 256);
    chk("s_blank_n_first", 32'(bn_first), 4);
    chk("s_rgb_active", 32'(r_hi), 256);
    chk("s_rgb_blank_leak", 32'(leak), 0);

    // Reset landing inside a VS pulse must release the pin at once and not resume it.
    vs_seen = 0;
    for (int k = 0; k < 1000 && vs_seen == 0; k++) begin
      @(negedge clk);
      if (!s_vs) vs_seen = 1;
    end
    chk("s_vs_wait", 32'(vs_seen), 1);
    rst_s = 1'b1;
    #1;
    chk("s_vsrst_sync", 32'({s_hs, s_vs, s_bn}), 32'b110);
    chk("s_vsrst_lock", 32'(s_lock), 0);
    @(negedge clk);
    rst_s = 1'b0;
    vs_lo = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!s_vs) vs_lo++;
    end
    chk("s_no_partial_vs", 32'(vs_lo), 0);

`ifdef VGA_TESTPAT_EN
    rst = 1'b1;
    testpat = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tp_mode = 1'b1;
    reset_model();
    rst = 1'b0;
    for (int k = 1; k <= 300; k++) step_a();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
